// File: rtl/axi_s_regfile_if.sv
// AXI4 bus bundle for the register-file slave: AW/W/B/AR/R channels.
// Widths must match the parameters of the slave attached to it.
interface axi_s_regfile_if #(
    parameter int IDLEN  = 4,
    parameter int AW     = 40,
    parameter int DW     = 64,
    parameter int BURSTL = 8
) ();
    logic [IDLEN-1:0]  awid;
    logic [AW-1:0]     awaddr;
    logic [BURSTL-1:0] awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid, awready;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   wstrb;
    logic              wlast, wvalid, wready;
    logic [IDLEN-1:0]  bid;
    logic [1:0]        bresp;
    logic              bvalid, bready;
    logic [IDLEN-1:0]  arid;
    logic [AW-1:0]     araddr;
    logic [BURSTL-1:0] arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid, arready;
    logic [IDLEN-1:0]  rid;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
    logic              rlast, rvalid, rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output awready, wready, bid, bresp, bvalid,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_s_regfile.sv
// AXI4 slave register file: NREGS x DW registers, FIXED/INCR/WRAP bursts, byte strobes,
// independent read/write FSMs, SLVERR on decode or format errors.
module axi_s_regfile #(
    parameter int            IDLEN     = 4,
    parameter int            AW        = 40,
    parameter int            DW        = 64,
    parameter int            BURSTL    = 8,
    parameter int            NREGS     = 16,
    parameter logic [AW-1:0] BASE      = '0,
    parameter logic [DW-1:0] RESET_VAL = '0
) (
    input  logic                clk,
    input  logic                rstn,
    axi_s_regfile_if.slave      s_axi,
    output logic [NREGS*DW-1:0] reg_q,
    output logic [NREGS-1:0]    reg_wr
);
    localparam int NB = DW / 8;
    localparam int LG = $clog2(NB);
    localparam int LN = $clog2(NREGS);

    typedef enum logic [1:0] {WIDLE, WDATA, WRESP} wstate_t;
    typedef enum logic       {RIDLE, RDATA} rstate_t;

    // Borrow out of the subtraction flags addr < BASE without a constant compare.
    function automatic logic f_bad(input logic [AW-1:0] a, input logic [2:0] sz,
                                   input logic [1:0] bu, input logic [BURSTL-1:0] ln);
        logic [AW:0] d;
        logic        wrap_ok;
        d       = {1'b0, a} - {1'b0, BASE};
        wrap_ok = (ln == BURSTL'(1)) || (ln == BURSTL'(3)) || (ln == BURSTL'(7)) || (ln == BURSTL'(15));
        f_bad   = d[AW] || ((d[AW-1:0] >> (LG + LN)) != '0) || (sz != 3'(LG)) ||
                  (bu == 2'd3) || ((bu == 2'd2) && !wrap_ok);
    endfunction

    function automatic logic [LN-1:0] f_idx(input logic [AW-1:0] a);
        logic [AW-1:0] d;
        d     = a - BASE;
        f_idx = d[LG +: LN];
    endfunction

    function automatic logic [AW-1:0] f_next(input logic [AW-1:0] a, input logic [1:0] bu,
                                             input logic [BURSTL-1:0] ln);
        logic [AW-1:0] inc, msk;
        inc = a + AW'(NB);
        msk = ((AW'(ln) + AW'(1)) << LG) - AW'(1);
        case (bu)
            2'd0:    f_next = a;
            2'd2:    f_next = (a & ~msk) | (inc & msk);
            default: f_next = inc;
        endcase
    endfunction

    logic                     r_alive;
    wstate_t                  r_wst, w_wst_nx;
    rstate_t                  r_rst, w_rst_nx;
    logic [IDLEN-1:0]         r_wid, r_rid;
    logic [AW-1:0]            r_waddr, r_raddr;
    logic [BURSTL-1:0]        r_wlen, r_wcnt, r_rlen, r_rcnt;
    logic [2:0]               r_wsize, r_rsize;
    logic [1:0]               r_wburst, r_rburst;
    logic                     r_werr;
    logic [NREGS-1:0]         r_reg_wr;
    logic [DW-1:0]            r_rhold;
    logic                     r_rhold_v;
    logic [NREGS-1:0][DW-1:0] w_regs;

    logic           w_aw_rdy, w_aw_hs, w_w_hs, w_wlast, w_wbad;
    logic           w_ar_rdy, w_ar_hs, w_rvalid, w_r_hs, w_rlast, w_rbad;
    logic [LN-1:0]  w_widx, w_ridx;
    logic [DW-1:0]  w_rdata_live;

    assign w_aw_rdy     = r_alive && (r_wst == WIDLE);
    assign w_aw_hs      = s_axi.awvalid && w_aw_rdy;
    assign w_w_hs       = s_axi.wvalid && (r_wst == WDATA);
    assign w_wlast      = (r_wcnt == r_wlen);
    assign w_wbad       = f_bad(r_waddr, r_wsize, r_wburst, r_wlen);
    assign w_widx       = f_idx(r_waddr);
    assign w_ar_rdy     = r_alive && (r_rst == RIDLE);
    assign w_ar_hs      = s_axi.arvalid && w_ar_rdy;
    assign w_rvalid     = (r_rst == RDATA);
    assign w_r_hs       = w_rvalid && s_axi.rready;
    assign w_rlast      = (r_rcnt == r_rlen);
    assign w_rbad       = f_bad(r_raddr, r_rsize, r_rburst, r_rlen);
    assign w_ridx       = f_idx(r_raddr);
    assign w_rdata_live = w_rbad ? '0 : w_regs[w_ridx];
    assign reg_q        = w_regs;
    assign reg_wr       = r_reg_wr;

    always_comb begin
        w_wst_nx      = r_wst;
        s_axi.awready = w_aw_rdy;
        s_axi.wready  = (r_wst == WDATA);
        s_axi.bvalid  = 1'b0;
        s_axi.bid     = '0;
        s_axi.bresp   = 2'b00;
        case (r_wst)
            WIDLE: if (w_aw_hs) w_wst_nx = WDATA;
            WDATA: if (w_w_hs && w_wlast) w_wst_nx = WRESP;
            WRESP: begin
                s_axi.bvalid = 1'b1;
                s_axi.bid    = r_wid;
                s_axi.bresp  = r_werr ? 2'b10 : 2'b00;
                if (s_axi.bready) w_wst_nx = WIDLE;
            end
            default: w_wst_nx = WIDLE;
        endcase
    end

    always_comb begin
        w_rst_nx      = r_rst;
        s_axi.arready = w_ar_rdy;
        s_axi.rvalid  = 1'b0;
        s_axi.rid     = '0;
        s_axi.rdata   = '0;
        s_axi.rresp   = 2'b00;
        s_axi.rlast   = 1'b0;
        case (r_rst)
            RIDLE: if (w_ar_hs) w_rst_nx = RDATA;
            RDATA: begin
                s_axi.rvalid = 1'b1;
                s_axi.rid    = r_rid;
                s_axi.rdata  = r_rhold_v ? r_rhold : w_rdata_live;
                s_axi.rresp  = w_rbad ? 2'b10 : 2'b00;
                s_axi.rlast  = w_rlast;
                if (w_r_hs && w_rlast) w_rst_nx = RIDLE;
            end
            default: w_rst_nx = RIDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_alive  <= 1'b0;
            r_wst    <= WIDLE;
            r_wid    <= '0;
            r_waddr  <= '0;
            r_wlen   <= '0;
            r_wsize  <= '0;
            r_wburst <= '0;
            r_wcnt   <= '0;
            r_werr   <= 1'b0;
            r_reg_wr <= '0;
        end else begin
            r_alive  <= 1'b1;
            r_wst    <= w_wst_nx;
            r_reg_wr <= '0;
            if (w_aw_hs) begin
                r_wid    <= s_axi.awid;
                r_waddr  <= s_axi.awaddr;
                r_wlen   <= s_axi.awlen;
                r_wsize  <= s_axi.awsize;
                r_wburst <= s_axi.awburst;
                r_wcnt   <= '0;
                r_werr   <= 1'b0;
            end
            if (w_w_hs) begin
                r_wcnt  <= r_wcnt + BURSTL'(1);
                r_waddr <= f_next(r_waddr, r_wburst, r_wlen);
                r_werr  <= r_werr | w_wbad | (s_axi.wlast != w_wlast);
                if (!w_wbad) r_reg_wr[w_widx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rst     <= RIDLE;
            r_rid     <= '0;
            r_raddr   <= '0;
            r_rlen    <= '0;
            r_rsize   <= '0;
            r_rburst  <= '0;
            r_rcnt    <= '0;
            r_rhold   <= '0;
            r_rhold_v <= 1'b0;
        end else begin
            r_rst <= w_rst_nx;
            if (w_ar_hs) begin
                r_rid    <= s_axi.arid;
                r_raddr  <= s_axi.araddr;
                r_rlen   <= s_axi.arlen;
                r_rsize  <= s_axi.arsize;
                r_rburst <= s_axi.arburst;
                r_rcnt   <= '0;
            end else if (w_r_hs && !w_rlast) begin
                r_rcnt  <= r_rcnt + BURSTL'(1);
                r_raddr <= f_next(r_raddr, r_rburst, r_rlen);
            end
            // Freeze the presented beat while stalled so concurrent writes cannot change it.
            if (w_rvalid && !s_axi.rready) begin
                r_rhold_v <= 1'b1;
                if (!r_rhold_v) r_rhold <= w_rdata_live;
            end else begin
                r_rhold_v <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_reg
        logic [DW-1:0] r_q;
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_q <= RESET_VAL;
            end else if (w_w_hs && !w_wbad && (w_widx == LN'(g))) begin
                for (int b = 0; b < NB; b++)
                    if (s_axi.wstrb[b]) r_q[b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
            end
        end
        assign w_regs[g] = r_q;
    end
endmodule
